// File: rtl/vga_rect_address_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_rect_address_gen
// Description : Streams raster-order frame-buffer addresses for a rectangle
//               over a valid/ready interface; one multiply per rectangle,
//               incremental adds per beat. Optional screen clipping is
//               enabled by defining VGA_RECT_CLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_address_gen #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 17
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int RBW = ADDR_W + COORD_W;
    localparam logic [RBW-1:0]     c_h_res_rb = RBW'(H_RES);
    localparam logic [COORD_W-1:0] c_one      = COORD_W'(1);

    if ((2 ** ADDR_W) < (H_RES * V_RES)) begin : g_addr_w_check
        $error("vga_rect_address_gen: ADDR_W too narrow for H_RES*V_RES");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_y0;
    logic [COORD_W-1:0] r_w;
    logic [COORD_W-1:0] r_h;
    logic [RBW-1:0]     r_row_base;
    logic [COORD_W-1:0] r_ew_m1;
    logic [COORD_W-1:0] r_col_cnt;
    logic [COORD_W-1:0] r_row_cnt;

    logic [COORD_W-1:0] w_ew;
    logic [COORD_W-1:0] w_eh;
    logic [RBW-1:0]     w_row_base;
    logic [RBW-1:0]     w_first_addr;
    logic [RBW-1:0]     w_next_row;
    logic [RBW-1:0]     w_next_row_addr;

`ifdef VGA_RECT_CLIP_EN
    localparam logic [COORD_W:0] c_h_res_x = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] c_v_res_x = (COORD_W+1)'(V_RES);

    logic [COORD_W:0] w_hspace;
    logic [COORD_W:0] w_vspace;

    // When the remaining screen span is chosen it is <= w, so it fits COORD_W.
    always_comb begin
        w_hspace = c_h_res_x - {1'b0, r_x0};
        w_vspace = c_v_res_x - {1'b0, r_y0};
        w_ew     = '0;
        w_eh     = '0;
        if ({1'b0, r_x0} < c_h_res_x) begin
            if ({1'b0, r_w} < w_hspace) w_ew = r_w;
            else                        w_ew = w_hspace[COORD_W-1:0];
        end
        if ({1'b0, r_y0} < c_v_res_x) begin
            if ({1'b0, r_h} < w_vspace) w_eh = r_h;
            else                        w_eh = w_vspace[COORD_W-1:0];
        end
    end
`else
    assign w_ew = r_w;
    assign w_eh = r_h;
`endif

    assign w_row_base      = RBW'(r_y0) * c_h_res_rb;
    assign w_first_addr    = w_row_base + RBW'(r_x0);
    assign w_next_row      = r_row_base + c_h_res_rb;
    assign w_next_row_addr = w_next_row + RBW'(r_x0);

    // Column/row down-counters track the walk, so x0+w never needs comparing.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_x0        <= '0;
            r_y0        <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_row_base  <= '0;
            r_ew_m1     <= '0;
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            start_ready <= 1'b1;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_x0        <= x0;
                        r_y0        <= y0;
                        r_w         <= w;
                        r_h         <= h;
                        r_state     <= S_CALC;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_row_base <= w_row_base;
                    r_ew_m1    <= w_ew - c_one;
                    r_col_cnt  <= w_ew - c_one;
                    r_row_cnt  <= w_eh - c_one;
                    if ((w_ew == '0) || (w_eh == '0)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state   <= S_RUN;
                        out_valid <= 1'b1;
                        out_addr  <= w_first_addr[ADDR_W-1:0];
                        out_x     <= r_x0;
                        out_y     <= r_y0;
                        out_last  <= (w_ew == c_one) && (w_eh == c_one);
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                        end else if (r_col_cnt == '0) begin
                            r_row_base <= w_next_row;
                            r_col_cnt  <= r_ew_m1;
                            r_row_cnt  <= r_row_cnt - c_one;
                            out_addr   <= w_next_row_addr[ADDR_W-1:0];
                            out_x      <= r_x0;
                            out_y      <= out_y + c_one;
                            out_last   <= (r_row_cnt == c_one) && (r_ew_m1 == '0);
                        end else begin
                            r_col_cnt <= r_col_cnt - c_one;
                            out_addr  <= out_addr + ADDR_W'(1);
                            out_x     <= out_x + c_one;
                            out_last  <= (r_row_cnt == '0) && (r_col_cnt == c_one);
                        end
                    end
                end
                S_DONE: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_address_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_rect_address_gen
// Description : Self-checking bench; expected beats come from the raster
//               formula address = y*H_RES + x over the (optionally clipped) box.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rect_address_gen;

    localparam int H_RES = 320;
    localparam int V_RES = 240;
    localparam int CW    = 10;
    localparam int AW    = 17;

    logic          clock;
    logic          resetn;
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] sx0, sy0, sw, sh;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [CW-1:0] out_x, out_y;
    logic          out_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int addr;
        int x;
        int y;
        bit last;
    } beat_t;

    beat_t exp_q[$];

    vga_rect_address_gen #(
        .H_RES(H_RES), .V_RES(V_RES), .COORD_W(CW), .ADDR_W(AW)
    ) dut (
        .clock(clock), .resetn(resetn),
        .start_valid(start_valid), .start_ready(start_ready),
        .x0(sx0), .y0(sy0), .w(sw), .h(sh),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic build_model(input int x0, input int y0, input int w, input int h);
        int ew, eh;
        beat_t b;
        exp_q.delete();
        ew = w;
        eh = h;
`ifdef VGA_RECT_CLIP_EN
        ew = (x0 >= H_RES) ? 0 : ((w < H_RES - x0) ? w : H_RES - x0);
        eh = (y0 >= V_RES) ? 0 : ((h < V_RES - y0) ? h : V_RES - y0);
`endif
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                b.addr = ((y0 + r) * H_RES + x0 + c) % (1 << AW);
                b.x    = (x0 + c) % (1 << CW);
                b.y    = (y0 + r) % (1 << CW);
                b.last = (r == eh - 1) && (c == ew - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // mode: 0 = ready always high, 1 = ready toggling (starting low), 2 = random ready
    task automatic run_rect(input int x0, input int y0, input int w, input int h,
                            input int mode, output int nbeats, output int last_addr);
        int    cyc;
        bit    rdy;
        bit    broken;
        beat_t b;
        nbeats    = 0;
        last_addr = -1;
        broken    = 0;
        build_model(x0, y0, w, h);
        cyc = 0;
        @(negedge clock);
        while (!start_ready && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_wait: start_ready=%0b required 1", start_ready);
        end
        sx0 = x0[CW-1:0];
        sy0 = y0[CW-1:0];
        sw  = w[CW-1:0];
        sh  = h[CW-1:0];
        start_valid = 1'b1;
        @(negedge clock);
        start_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL calc_cycle: busy=%0b out_valid=%0b start_ready=%0b required 1/0/0",
                     busy, out_valid, start_ready);
        end
        @(negedge clock);
        if (exp_q.size() == 0) begin
            checks++;
            if (done !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_done: done=%0b out_valid=%0b required 1/0", done, out_valid);
            end
            @(negedge clock);
            checks++;
            if (start_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL empty_idle: start_ready=%0b done=%0b busy=%0b required 1/0/0",
                         start_ready, done, busy);
            end
            return;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid: out_valid=%0b required 1 at T+2", out_valid);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000 && !broken) begin
            checks++;
            if (out_valid === 1'b1) begin
                b = exp_q[0];
                if (out_addr !== AW'(b.addr) || out_x !== CW'(b.x) || out_y !== CW'(b.y) ||
                    out_last !== b.last || done !== 1'b0) begin
                    errors++;
                    $display("FAIL beat: addr=%0d x=%0d y=%0d last=%0b done=%0b required addr=%0d x=%0d y=%0d last=%0b done=0",
                             out_addr, out_x, out_y, out_last, done, b.addr, b.x, b.y, b.last);
                end
            end else begin
                errors++;
                broken = 1;
                $display("FAIL valid_drop: out_valid=%0b required 1 with %0d beats pending",
                         out_valid, exp_q.size());
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = cyc[0];
            else                rdy = ($urandom_range(0, 3) != 0);
            out_ready = rdy;
            if (rdy && out_valid === 1'b1) begin
                last_addr = int'(out_addr);
                nbeats++;
                void'(exp_q.pop_front());
            end
            @(negedge clock);
            cyc++;
        end
        out_ready = 1'b0;
        if (broken || exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL walk_incomplete: pending=%0d required 0", exp_q.size());
            repeat (2000) begin
                if (!busy) break;
                @(negedge clock);
            end
            return;
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%0b out_valid=%0b required 1/0", done, out_valid);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL return_idle: done=%0b start_ready=%0b busy=%0b required 0/1/0",
                     done, start_ready, busy);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_addr !== '0 || out_x !== '0 || out_y !== '0 ||
            out_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%0b addr=%0d x=%0d y=%0d last=%0b done=%0b busy=%0b sready=%0b required 0/0/0/0/0/0/0/1",
                     out_valid, out_addr, out_x, out_y, out_last, done, busy, start_ready);
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        int n, a;
        run_rect(0, 0, 2, 2, 0, n, a);
        checks++;
        if (n != 4 || a != 321) begin
            errors++;
            $display("FAIL basic_2x2: beats=%0d last_addr=%0d required 4/321", n, a);
        end
    endtask

    task automatic test_backpressure();
        int n, a;
        run_rect(10, 5, 3, 1, 1, n, a);
        checks++;
        if (n != 3 || a != 1612) begin
            errors++;
            $display("FAIL backpressure: beats=%0d last_addr=%0d required 3/1612", n, a);
        end
    endtask

    task automatic test_edge_rect();
        int n, a, en, ea;
`ifdef VGA_RECT_CLIP_EN
        en = 2;
        ea = 76799;
`else
        en = 12;
        ea = 77441;
`endif
        run_rect(318, 239, 4, 3, 2, n, a);
        checks++;
        if (n != en || a != ea) begin
            errors++;
            $display("FAIL edge_rect: beats=%0d last_addr=%0d required %0d/%0d", n, a, en, ea);
        end
    endtask

    task automatic test_empty();
        int n, a;
        run_rect(7, 9, 0, 5, 0, n, a);
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL empty_beats: beats=%0d required 0", n);
        end
    endtask

    task automatic test_reset_midrun();
        int n, a, cyc;
        cyc = 0;
        while (!start_ready && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        sx0 = 10'd5; sy0 = 10'd5; sw = 10'd4; sh = 10'd4;
        start_valid = 1'b1;
        @(negedge clock);
        start_valid = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn    = 1'b1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: valid=%0b busy=%0b sready=%0b done=%0b required 0/0/1/0",
                     out_valid, busy, start_ready, done);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%0b valid=%0b required 0/0", done, out_valid);
        end
        run_rect(1, 1, 1, 1, 0, n, a);
        checks++;
        if (n != 1 || a != 321) begin
            errors++;
            $display("FAIL after_reset: beats=%0d last_addr=%0d required 1/321", n, a);
        end
    endtask

    task automatic test_start_ignored();
        int cyc, nb;
        cyc = 0;
        while (!start_ready && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        sx0 = 10'd2; sy0 = 10'd3; sw = 10'd3; sh = 10'd2;
        start_valid = 1'b1;
        @(negedge clock);
        sx0 = 10'd50; sy0 = 10'd7; sw = 10'd2; sh = 10'd1;
        out_ready = 1'b1;
        cyc = 0;
        nb  = 0;
        while (done !== 1'b1 && cyc < 50) begin
            checks++;
            if (start_ready !== 1'b0) begin
                errors++;
                $display("FAIL start_ignored: start_ready=%0b required 0 while busy", start_ready);
            end
            if (out_valid === 1'b1) nb++;
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || nb != 6 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_rect: done=%0b beats=%0d sready=%0b required 1/6/0", done, nb, start_ready);
        end
        @(negedge clock);
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_done: start_ready=%0b required 1", start_ready);
        end
        @(negedge clock);
        start_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL held_accept: busy=%0b sready=%0b required 1/0", busy, start_ready);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 17'd2290 || out_x !== 10'd50 || out_y !== 10'd7) begin
            errors++;
            $display("FAIL held_first_beat: valid=%0b addr=%0d x=%0d y=%0d required 1/2290/50/7",
                     out_valid, out_addr, out_x, out_y);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL held_done: done=%0b required 1", done);
        end
        out_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_random();
        int n, a;
        for (int i = 0; i < 25; i++) begin
            run_rect($urandom_range(0, 330), $urandom_range(0, 250),
                     $urandom_range(0, 6), $urandom_range(0, 4), 2, n, a);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        start_valid = 1'b0;
        out_ready   = 1'b0;
        sx0 = '0; sy0 = '0; sw = '0; sh = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_edge_rect();
        test_empty();
        test_reset_midrun();
        test_start_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_rect_address_gen.md
# vga_rect_address_gen

Sequential, parametrised address generator for the VGA frame buffer. It accepts a rectangle (origin, width, height), then streams one linear frame-buffer address per cycle in raster order (`address = y*H_RES + x`) over a valid/ready interface. It sits between sprite/tile drawing logic (bombs, walls, players) and the frame-buffer write port. It replaces per-pixel combinational address translation with a single multiply per rectangle followed by incremental adds.

## Interface
Parameters:
- `H_RES`, default 320: frame-buffer width in pixels.
- `V_RES`, default 240: frame-buffer height in pixels.
- `COORD_W`, default 10: width of all coordinate and size fields.
- `ADDR_W`, default 17: address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES.

Ports:
- `clock`  in  1  single clock; all logic rising-edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start_valid`  in  1  rectangle request present.
- `start_ready`  out  1  high only in IDLE.
- `x0`, `y0`  in  COORD_W each  rectangle origin, sampled on start handshake.
- `w`, `h`  in  COORD_W each  rectangle size in pixels, sampled on start handshake.
- `out_valid`  out  1  `out_addr`/`out_x`/`out_y`/`out_last` valid.
- `out_ready`  in  1  consumer accepts the current beat.
- `out_addr`  out  ADDR_W  linear frame-buffer address.
- `out_x`, `out_y`  out  COORD_W each  pixel coordinates of the current beat.
- `out_last`  out  1  final beat of the rectangle.
- `busy`  out  1  high in CALC, RUN and DONE.
- `done`  out  1  one-cycle pulse when the rectangle is finished.

## Operation
- FSM states are IDLE, CALC, RUN and DONE. The state resets to IDLE.
- **IDLE → CALC** on `start_valid && start_ready`. Latch `x0`, `y0`, `w`, `h`.
- **CALC** lasts exactly one cycle:
  - Compute `row_base = y0*H_RES`.
  - Compute effective width `ew` and effective height `eh` (see Configuration).
  - If `ew==0` or `eh==0`, go to DONE. Otherwise go to RUN.
- **RUN**:
  - Emits beat `(x, y)`, starting at `(x0, y0)`, with `out_addr = row_base + x` truncated to ADDR_W.
  - On each handshake (`out_valid && out_ready`), x increments.
  - After the beat at `x == x0+ew-1`: x returns to `x0`, y increments, and `row_base += H_RES`.
  - `out_last` is high on the beat at `(x0+ew-1, y0+eh-1)`. The handshake of that beat moves the FSM to DONE.
- **DONE**: `done` is high for one cycle, then the FSM returns to IDLE.
- Arithmetic widths:
  - Internal end-coordinate sums (`x0+w`, `y0+h`) use COORD_W+1 bits, so there is no overflow.
  - `row_base` and the address adder use ADDR_W+COORD_W bits and are truncated on output.
- Reset values of outputs: `out_valid`=0, `out_addr`=0, `out_x`=0, `out_y`=0, `out_last`=0, `done`=0, `busy`=0, `start_ready`=1.
- A reset asserted mid-operation aborts the walk. The block returns to IDLE with the reset values above; no `done` pulse is produced.
- `start_valid` is ignored while `busy`.

## Timing
- Start accepted at cycle T; CALC occurs at T+1; first `out_valid` is at T+2.
- Throughput is one beat per cycle while `out_ready` is high.
- While `out_valid && !out_ready`, all `out_*` signals hold stable. `out_valid` does not drop before the handshake.
- `done` is high on the cycle after the last handshake. For an empty rectangle, `done` is high at T+2.
- `start_ready` rises the cycle after `done`, so the earliest next acceptance is at T_done+1.

## Configuration
- Macro: `VGA_RECT_CLIP_EN`.
- **Defined**: CALC clips the rectangle to the screen.
  - `ew = (x0 ≥ H_RES) ? 0 : min(w, H_RES-x0)`.
  - `eh = (y0 ≥ V_RES) ? 0 : min(h, V_RES-y0)`.
  - Off-screen pixels are never emitted, and `out_last` marks the last clipped pixel.
- **Undefined**: `ew = w` and `eh = h`, with no bounds check.
  - Off-screen coordinates are emitted as-is.
  - Addresses wrap modulo 2^ADDR_W.

## Test plan
1. x0=0, y0=0, w=2, h=2, `out_ready`=1 → addresses 0, 1, 320, 321. `out_last` is high only on 321. First valid at T+2; `done` high the cycle after the 321 handshake.
2. x0=10, y0=5, w=3, h=1, with `out_ready` toggling 0/1 → addresses 1610, 1611, 1612. Each beat holds stable while ready=0. No beat is lost or duplicated.
3. x0=318, y0=239, w=4, h=3:
   - Clip on → 76798, 76799, then `done`.
   - Clip off → 12 beats 76798..76801, 77118..77121, 77438..77441; `out_y` reaches 241.
4. w=0, h=5 → no `out_valid`; `done` high at T+2; `start_ready` high at T+3.
5. `resetn` low for one cycle during RUN of a 4×4 rectangle → next cycle `out_valid`=0, `busy`=0, `start_ready`=1, no `done`. A following 1×1 start at (1,1) yields the single address 321.
6. `start_valid` held high with different x0 during RUN → the request is ignored (`start_ready`=0). It is accepted on the cycle after `done`.
